// File: rtl/pwm_dec_pkg.sv
// pwm_dec_pkg: shared FSM states, sample width and duty scaling for the PWM decoder.
package pwm_dec_pkg;
  localparam int SAMPLE_W = 8;
  localparam int DEFAULT_PERIOD = 256;
  localparam logic [31:0] SAMPLE_MAX = 32'(2 ** SAMPLE_W - 1);
  typedef enum logic [1:0] {IDLE, HUNT, MEASURE} state_t;
  // Scales a high count to the 8-bit duty range; period is a constant at every call site.
  function automatic logic [SAMPLE_W-1:0] scale_duty(input logic [31:0] count, input logic [31:0] period);
    logic [31:0] q;
    q = (count << SAMPLE_W) / period;
    return (q > SAMPLE_MAX) ? SAMPLE_MAX[SAMPLE_W-1:0] : q[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/pwm_dec_sync.sv
// pwm_dec_sync: synchronizer, optional majority filter (PWM_DEC_GLITCH_FILTER_EN) and edge detect.
module pwm_dec_sync
  import pwm_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_s;
  logic r_rise;
  logic w_in;
`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic [1:0] r_tap;
  // Majority of the newest synced bit and two older ones: adds one cycle, drops 1-cycle pulses.
  always_ff @(posedge clk) r_tap <= rst ? 2'b00 : {r_tap[0], r_sync[SYNC_STAGES-1]};
  assign w_in = (r_sync[SYNC_STAGES-1] & r_tap[0]) | (r_sync[SYNC_STAGES-1] & r_tap[1]) | (r_tap[0] & r_tap[1]);
`else
  assign w_in = r_sync[SYNC_STAGES-1];
`endif
  always_ff @(posedge clk) begin
    r_sync <= rst ? '0 : {r_sync[SYNC_STAGES-2:0], pwm_in};
    r_s <= rst ? 1'b0 : w_in;
    r_rise <= rst ? 1'b0 : w_in & ~r_s;
  end
  assign s = r_s;
  assign rise = r_rise;
endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers 8-bit duty samples from a PWM stream in PERIOD-cycle windows aligned to rising edges.
// Define PWM_DEC_GLITCH_FILTER_EN to add a 3-tap majority filter on the input.
module pwm_decoder
  import pwm_dec_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  input  logic                enable,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                locked,
  output logic                phase_err
);
  localparam int CW = $clog2(PERIOD);
  localparam int HW = CW + 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_high;
  logic r_seen;
  logic r_valid;
  logic r_locked;
  logic r_perr;
  logic [SAMPLE_W-1:0] r_sample;
  logic w_s;
  logic w_rise;
  logic w_first;
  logic w_last;
  logic w_seen;
  logic [HW-1:0] w_high;

  pwm_dec_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .s(w_s),
    .rise(w_rise)
  );

  // Count and rise history restart on window cycle 0 so back-to-back windows need no gap.
  assign w_first = r_cnt == '0;
  assign w_last = r_cnt == LAST;
  assign w_high = (w_first ? '0 : r_high) + HW'(w_s);
  assign w_seen = (!w_first && r_seen) || w_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_high <= '0;
      r_seen <= 1'b0;
      r_sample <= '0;
      r_valid <= 1'b0;
      r_locked <= 1'b0;
      r_perr <= 1'b0;
    end else if (!enable) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_high <= '0;
      r_seen <= 1'b0;
      r_valid <= 1'b0;
      r_locked <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: r_state <= HUNT;
        HUNT: if (w_rise) begin
          r_state <= MEASURE;
          r_cnt <= CW'(1);
          r_high <= HW'(1);
          r_seen <= 1'b1;
        end
        default: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          r_high <= w_high;
          r_seen <= w_seen;
          // A continuing window always follows one that held a rise, so a rise on cycle 0 means aligned.
          if (w_first) r_locked <= w_rise;
          else if (w_rise) begin
            r_locked <= 1'b0;
            r_perr <= 1'b1;
          end
          if (w_last) begin
            r_sample <= scale_duty(32'(w_high), 32'(PERIOD));
            r_valid <= 1'b1;
            if (!w_seen) begin
              r_state <= HUNT;
              r_locked <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign sample = r_sample;
  assign sample_valid = r_valid;
  assign locked = r_locked;
  assign phase_err = r_perr;
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: randomized PWM stimulus scored against a window-sum reference model.
module tb_pwm_decoder;
  localparam int P = 256;
  localparam int S = 2;
  localparam int MAXC = 80000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_in = 1'b0;
  logic enable = 1'b0;
  logic [7:0] sample;
  logic sample_valid;
  logic locked;
  logic phase_err;

  pwm_decoder #(.PERIOD(P), .SYNC_STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .enable(enable),
    .sample(sample),
    .sample_valid(sample_valid),
    .locked(locked),
    .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    logic [7:0] smp;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit xh [0:MAXC-1];
  int last_rst = -1;
  int mode = 0;
  int ws = 0;
  bit lk = 1'b0;
  bit pe = 1'b0;
  bit prev_had = 1'b0;
  logic [7:0] msmp = 8'h00;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc - 1);
    end
  endtask

  // Input level sampled at edge k, with everything up to the last reset reading as 0.
  function automatic bit hx(int k);
    return (k > last_rst && k >= 0) ? xh[k] : 1'b0;
  endfunction

  // Level the decoder acts on at edge e, after synchronizer (and filter) latency.
  function automatic bit s_at(int e);
`ifdef PWM_DEC_GLITCH_FILTER_EN
    return (int'(hx(e - S - 1)) + int'(hx(e - S - 2)) + int'(hx(e - S - 3))) >= 2;
`else
    return hx(e - S - 1);
`endif
  endfunction

  function automatic bit rise_at(int e);
    return s_at(e) && !s_at(e - 1);
  endfunction

  // Reference model: mode 0 idle, 1 hunting, 2 measuring a window that began at edge ws.
  always @(posedge clk) begin : model
    int e, idx, cnt, nr, q;
    exp_t t;
    e = cyc;
    xh[e] = pwm_in;
    if (rst) begin
      last_rst = e;
      mode = 0;
      lk = 1'b0;
      pe = 1'b0;
      prev_had = 1'b0;
      msmp = 8'h00;
    end else if (!enable) begin
      mode = 0;
      lk = 1'b0;
      pe = 1'b0;
    end else if (mode == 0) begin
      mode = 1;
    end else begin
      if (mode == 1 && rise_at(e)) begin
        mode = 2;
        ws = e;
        prev_had = 1'b0;
      end
      if (mode == 2) begin
        idx = e - ws;
        if (idx == 0) lk = rise_at(e) && prev_had;
        else if (rise_at(e)) begin
          lk = 1'b0;
          pe = 1'b1;
        end
        if (idx == P - 1) begin
          cnt = 0;
          nr = 0;
          for (int k = ws; k <= e; k++) begin
            cnt += int'(s_at(k));
            nr += int'(rise_at(k));
          end
          q = cnt * 256 / P;
          msmp = (q > 255) ? 8'hFF : 8'(q);
          t.tag = e;
          t.smp = msmp;
          exp_q.push_back(t);
          prev_had = nr > 0;
          ws = e + 1;
          if (!prev_had) begin
            lk = 1'b0;
            mode = 1;
          end
        end
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: strobes are popped from the scoreboard; held outputs are compared every cycle.
  always @(negedge clk) begin : monitor
    bit due;
    exp_t t;
    if (cyc > 0) begin
      due = exp_q.size() > 0 && exp_q[0].tag == cyc - 1;
      chk("sample_valid", int'(sample_valid), int'(due));
      if (due) begin
        t = exp_q.pop_front();
        if (sample_valid) chk("strobe_sample", int'(sample), int'(t.smp));
      end
      chk("sample_hold", int'(sample), int'(msmp));
      chk("locked", int'(locked), int'(lk));
      chk("phase_err", int'(phase_err), int'(pe));
    end
  end

  task automatic drive(bit v, bit r = 1'b0);
    @(negedge clk);
    pwm_in = v;
    rst = r;
  endtask

  task automatic frame(int d, int extra = 0, int gpos = -1);
    for (int i = 0; i < P + extra; i++) drive(i < d || i == gpos);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    after_edge();
    chk("reset_sample", int'(sample), 0);
    chk("reset_valid", int'(sample_valid), 0);
    chk("reset_locked", int'(locked), 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    repeat (6) frame(8'h80);
    after_edge();
    chk("stream80_sample", int'(sample), 8'h80);
    chk("stream80_locked", int'(locked), 1);
    chk("stream80_perr", int'(phase_err), 0);
    repeat (3) frame(0);
    after_edge();
    chk("zero_sample", int'(sample), 0);
    chk("zero_locked", int'(locked), 0);
    repeat (3) frame(8'hFF);
    repeat (3 * P) drive(1'b1);
    after_edge();
    chk("const_high_sample", int'(sample), 8'hFF);
    chk("const_high_locked", int'(locked), 0);
    repeat (10) drive(1'b0);
    repeat (2) frame(8'h40);
    for (int i = 0; i < 100; i++) drive(i < 8'h40);
    drive(1'b0, 1'b1);
    after_edge();
    chk("midrst_sample", int'(sample), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_valid", int'(sample_valid), 0);
    for (int i = 101; i < P; i++) drive(i < 8'h40);
    repeat (3) frame(8'h40);
    after_edge();
    chk("relock_locked", int'(locked), 1);
    chk("relock_sample", int'(sample), 8'h40);
    repeat (3) frame(8'h60);
    frame(8'h60, 3);
    repeat (2) frame(8'h60);
    after_edge();
    chk("slip_perr", int'(phase_err), 1);
    chk("slip_locked", int'(locked), 0);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    after_edge();
    chk("disable_perr", int'(phase_err), 0);
    @(negedge clk);
    enable = 1'b1;
    repeat (2) frame(8'h30);
    frame(8'h30, 0, 150);
    repeat (2) frame(8'h30);
    for (int f = 0; f < 30; f++) begin
      int d, ex, gp;
      d = int'($urandom_range(0, 255));
      ex = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
      gp = (d < 240 && $urandom_range(0, 5) == 0) ? int'($urandom_range(d + 2, P - 4)) : -1;
      if ($urandom_range(0, 14) == 0) begin
        @(negedge clk);
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        enable = 1'b1;
      end
      frame(d, ex, gp);
    end
    repeat (2) frame(0);
    repeat (10) @(negedge clk);
    after_edge();
    chk("final_locked", int'(locked), 0);
    chk("final_sample", int'(sample), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
